// File: rtl/char_buf_scan_reader_if.sv
// SRAM read-port and character-stream signals of the raster-scan reader.
// master = reader side, slave = SRAM + glyph-expansion side.
interface char_buf_scan_reader_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_readdata;

  logic [10:0]       st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_startofpacket;
  logic              st_endofpacket;

  modport master (
    output mem_address, mem_chipselect, mem_clken, mem_write, mem_byteenable,
    input  mem_readdata,
    output st_data, st_valid, st_startofpacket, st_endofpacket,
    input  st_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_clken, mem_write, mem_byteenable,
    output mem_readdata,
    input  st_data, st_valid, st_startofpacket, st_endofpacket,
    output st_ready
  );
endinterface

// File: rtl/char_buf_scan_reader.sv
// Walks the character SRAM in raster order (col, glyph line, row) and streams
// one {glyph_line, char_code} beat per cell per scan line, one packet per frame.
module char_buf_scan_reader #(
  parameter int CHAR_COLS   = 80,
  parameter int CHAR_ROWS   = 60,
  parameter int GLYPH_LINES = 8,
  parameter int ROW_WORDS   = 32,
  parameter int ADDR_W      = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  char_buf_scan_reader_if.master bus
);

  localparam int COL_W = (CHAR_COLS > 4) ? $clog2(CHAR_COLS) : 2;
  localparam int ROW_W = (CHAR_ROWS > 1) ? $clog2(CHAR_ROWS) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(CHAR_COLS - 1);
  localparam logic [2:0]        LINE_LAST = 3'(GLYPH_LINES - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(CHAR_ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(ROW_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [2:0] line;
    logic [7:0] code;
  } beat_t;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [2:0]        line_q, line_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q;

  logic              pipe_vld_q;
  logic [1:0]        pipe_lane_q;
  logic [2:0]        pipe_line_q;
  logic              pipe_sop_q;
  logic              pipe_eop_q;

  beat_t             fifo_mem [4];
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        cnt_q, cnt_d;

  logic [ADDR_W-1:0] cell_addr;
  logic              first_cell, last_cell;
  logic [2:0]        occupancy;
  logic              issue, push, pop;
  logic [7:0]        lane_byte;
  beat_t             head;

  assign cell_addr  = row_base_q + ADDR_W'(col_q >> 2);
  assign first_cell = (col_q == '0) && (line_q == '0) && (row_q == '0);
  assign last_cell  = (col_q == COL_LAST) && (line_q == LINE_LAST) && (row_q == ROW_LAST);
  assign occupancy  = cnt_q + {2'b00, pipe_vld_q};
  assign push       = pipe_vld_q;
  assign pop        = (cnt_q != 3'd0) && bus.st_ready;
  assign lane_byte  = bus.mem_readdata[{pipe_lane_q, 3'b000} +: 8];

  // NOTE: state lives in always_ff with non-blocking assignments only, so every
  // register samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = SCAN;
      SCAN:    if (issue && last_cell) state_d = DRAIN;
      DRAIN:   if (!pipe_vld_q && (cnt_q == 3'd0)) state_d = enable ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A read may issue only while the FIFO can still absorb it plus whatever is in flight.
  always_comb begin
    issue              = (state_q == SCAN) && (occupancy <= 3'd2);
    bus.mem_chipselect = issue;
    bus.mem_address    = issue ? cell_addr : addr_q;
  end

  always_comb begin
    col_d      = col_q;
    line_d     = line_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    if (issue) begin
      if (last_cell) begin
        col_d      = '0;
        line_d     = '0;
        row_d      = '0;
        row_base_d = '0;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        if (line_q == LINE_LAST) begin
          line_d     = '0;
          row_d      = row_q + 1'b1;
          row_base_d = row_base_q + ROW_STEP;
        end else begin
          line_d = line_q + 3'd1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q      <= '0;
      line_q     <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      col_q      <= col_d;
      line_q     <= line_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      if (issue) addr_q <= cell_addr;
    end
  end

  // Side-band for the read in flight; it meets mem_readdata one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld_q  <= 1'b0;
      pipe_lane_q <= '0;
      pipe_line_q <= '0;
      pipe_sop_q  <= 1'b0;
      pipe_eop_q  <= 1'b0;
    end else begin
      pipe_vld_q <= issue;
      if (issue) begin
        pipe_lane_q <= col_q[1:0];
        pipe_line_q <= line_q;
        pipe_sop_q  <= first_cell;
        pipe_eop_q  <= last_cell;
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; an entry is only observable
  // once the reset count marks it valid, so clearing it would be pure overhead.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{sop: pipe_sop_q, eop: pipe_eop_q,
                                      line: pipe_line_q, code: lane_byte};
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      cnt_q <= cnt_d;
    end
  end

  assign head = fifo_mem[rd_ptr_q];

  // Head fields are masked while empty so the stream reads all-zero out of reset.
  always_comb begin
    bus.st_valid         = (cnt_q != 3'd0);
    bus.st_data          = bus.st_valid ? {head.line, head.code} : 11'd0;
    bus.st_startofpacket = bus.st_valid && head.sop;
    bus.st_endofpacket   = bus.st_valid && head.eop;
  end

  assign bus.mem_clken      = 1'b1;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;

endmodule

// File: tb/tb_char_buf_scan_reader.sv
// Directed bench for char_buf_scan_reader: a small 8x2x2 instance against a
// queue of expected beats, plus one full default-size frame.
module tb_char_buf_scan_reader;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic enable_d;

  always #5 clk = ~clk;

  char_buf_scan_reader_if #(.ADDR_W(11)) bus_s ();
  char_buf_scan_reader_if #(.ADDR_W(11)) bus_d ();

  char_buf_scan_reader #(
    .CHAR_COLS(8), .CHAR_ROWS(2), .GLYPH_LINES(2), .ROW_WORDS(2), .ADDR_W(11)
  ) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus_s)
  );

  char_buf_scan_reader dut_d (
    .clk(clk), .reset(reset), .enable(enable_d), .bus(bus_d)
  );

  logic [31:0] mem_s [4];

  function automatic logic [31:0] dmem(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {b ^ 8'h3C, b + 8'd17, ~b, b};
  endfunction

  always @(posedge clk) begin
    if (bus_s.mem_chipselect)
      bus_s.mem_readdata <= (bus_s.mem_address < 11'd4) ? mem_s[bus_s.mem_address[1:0]]
                                                        : 32'hDEAD_BEEF;
    if (bus_d.mem_chipselect)
      bus_d.mem_readdata <= dmem(int'(bus_d.mem_address));
  end

  int          n_err = 0;
  int          n_chk = 0;
  logic [12:0] exp_q [$];
  int          mode;
  int          cyc;
  int          issued;
  int          accepted;
  int          max_occ;
  int          first_valid_cyc;
  int          last_eop_cyc;
  int          first_gap;
  bit          prev_stall;
  logic [13:0] prev_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    logic [31:0] w;
    logic [7:0]  b;
    bit          sop, eop;
    for (int row = 0; row < 2; row++)
      for (int line = 0; line < 2; line++)
        for (int col = 0; col < 8; col++) begin
          w   = mem_s[row * 2 + col / 4];
          b   = w[8 * (col % 4) +: 8];
          sop = (row == 0) && (line == 0) && (col == 0);
          eop = (row == 1) && (line == 1) && (col == 7);
          exp_q.push_back({sop, eop, 3'(line), b});
        end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_st_valid"}, 32'(bus_s.st_valid), 0);
    check({pfx, "_sop"},      32'(bus_s.st_startofpacket), 0);
    check({pfx, "_eop"},      32'(bus_s.st_endofpacket), 0);
    check({pfx, "_st_data"},  32'(bus_s.st_data), 0);
    check({pfx, "_cs"},       32'(bus_s.mem_chipselect), 0);
    check({pfx, "_addr"},     32'(bus_s.mem_address), 0);
    check({pfx, "_clken"},    32'(bus_s.mem_clken), 1);
    check({pfx, "_write"},    32'(bus_s.mem_write), 0);
    check({pfx, "_be"},       32'(bus_s.mem_byteenable), 32'hF);
  endtask

  // One clock of the small instance: drive st_ready, score any accepted beat.
  task automatic step();
    logic        r;
    logic [12:0] e;
    logic [13:0] cur;
    @(negedge clk);
    cyc++;
    case (mode)
      0:       r = 1'b1;
      1:       r = 1'($urandom_range(0, 1));
      default: r = 1'b0;
    endcase
    bus_s.st_ready = r;
    if (bus_s.mem_chipselect) issued++;
    cur = {bus_s.st_valid, bus_s.st_startofpacket, bus_s.st_endofpacket, bus_s.st_data};
    if (bus_s.st_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stall) check("stall_hold", 32'(cur), 32'(prev_out));
    if (bus_s.st_valid && r) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(cur), 0);
      end else begin
        e = exp_q.pop_front();
        check("beat", 32'(cur[12:0]), 32'(e));
      end
      accepted++;
      if (bus_s.st_startofpacket && last_eop_cyc >= 0 && first_gap < 0)
        first_gap = cyc - last_eop_cyc - 1;
      if (bus_s.st_endofpacket) last_eop_cyc = cyc;
    end
    prev_stall = bus_s.st_valid && !r;
    prev_out   = cur;
    if (issued - accepted > max_occ) max_occ = issued - accepted;
  endtask

  task automatic run_to(input int target, input int bound, input string tag);
    for (int i = 0; i < bound && accepted < target; i++) step();
    check(tag, 32'(accepted), 32'(target));
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    int          acc0;
    int          col, line, row, beats, bad, eop_idx, d_issues;
    logic [31:0] last_addr, w;
    logic [7:0]  b;
    logic [12:0] got, want;

    mem_s[0] = 32'h4443_4241;
    mem_s[1] = 32'h4847_4645;
    mem_s[2] = 32'h6463_6261;
    mem_s[3] = 32'h6867_6665;
    reset = 1'b1;
    enable = 1'b0;
    enable_d = 1'b0;
    bus_s.st_ready = 1'b0;
    bus_d.st_ready = 1'b0;
    mode = 2;
    cyc = 0;
    issued = 0;
    accepted = 0;
    max_occ = 0;
    first_valid_cyc = -1;
    last_eop_cyc = -1;
    first_gap = -1;
    prev_stall = 1'b0;
    prev_out = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Frames A, B at full rate, frame C with random backpressure.
    push_frame();
    push_frame();
    push_frame();
    mode = 0;
    enable = 1'b1;
    cyc = 0;
    step();
    check("first_issue_cs", 32'(bus_s.mem_chipselect), 1);
    check("first_issue_addr", 32'(bus_s.mem_address), 0);
    run_to(64, 300, "frames_ab_done");
    check("startup_latency", 32'(first_valid_cyc), 3);
    check("frame_gap", 32'(first_gap), 3);

    mode = 1;
    run_to(74, 400, "frame_c_partial");
    enable = 1'b0;
    run_to(96, 1000, "frame_c_done");
    repeat (20) step();
    check("issued_after_idle", 32'(issued), 96);
    check("idle_st_valid", 32'(bus_s.st_valid), 0);
    check("max_occupancy_ok", 32'(max_occ <= 6), 1);
    check("queue_empty_c", 32'(exp_q.size()), 0);

    // Re-raise enable: restart at address 0 with SOP.
    push_frame();
    mode = 0;
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus_s.mem_chipselect) begin
        seen = 1'b1;
        check("restart_addr", 32'(bus_s.mem_address), 0);
      end
    end
    check("restart_issue_seen", 32'(seen), 1);
    run_to(101, 100, "frame_d_partial");
    enable = 1'b0;
    run_to(128, 200, "frame_d_done");
    repeat (10) step();
    check("issued_after_d", 32'(issued), 128);

    // Downstream stalled from the start.
    push_frame();
    mode = 2;
    enable = 1'b1;
    repeat (20) step();
    check("stall_issued", 32'(issued), 131);
    check("stall_cs_low", 32'(bus_s.mem_chipselect), 0);
    check("stall_valid", 32'(bus_s.st_valid), 1);
    check("stall_data", 32'(bus_s.st_data), 32'h041);
    check("stall_sop", 32'(bus_s.st_startofpacket), 1);

    // Release, take 10 beats, then reset with beat 10 at the head.
    mode = 0;
    run_to(138, 100, "frame_e_ten");
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    push_frame();
    acc0 = accepted;
    run_to(acc0 + 5, 50, "frame_f_partial");
    enable = 1'b0;
    run_to(acc0 + 32, 200, "frame_f_done");
    repeat (10) step();
    check("queue_empty_f", 32'(exp_q.size()), 0);

    // Full default-size frame, downstream always ready.
    bus_d.st_ready = 1'b1;
    enable_d = 1'b1;
    col = 0; line = 0; row = 0;
    beats = 0; bad = 0; eop_idx = -1; d_issues = 0; last_addr = '0;
    for (int i = 0; i < 40000 && beats < 38400; i++) begin
      @(negedge clk);
      if (i == 5) enable_d = 1'b0;
      if (bus_d.mem_chipselect) begin
        last_addr = 32'(bus_d.mem_address);
        d_issues++;
      end
      if (bus_d.st_valid) begin
        w    = dmem(row * 32 + col / 4);
        b    = w[8 * (col % 4) +: 8];
        want = {1'(beats == 0), 1'(beats == 38399), 3'(line), b};
        got  = {bus_d.st_startofpacket, bus_d.st_endofpacket, bus_d.st_data};
        if (got !== want) bad++;
        if (bus_d.st_endofpacket) eop_idx = beats;
        beats++;
        if (col == 79) begin
          col = 0;
          if (line == 7) begin
            line = 0;
            row = (row == 59) ? 0 : row + 1;
          end else begin
            line++;
          end
        end else begin
          col++;
        end
      end
    end
    repeat (10) @(negedge clk);
    if (bus_d.mem_chipselect) d_issues++;
    check("dflt_beats", 32'(beats), 38400);
    check("dflt_bad_beats", 32'(bad), 0);
    check("dflt_eop_index", 32'(eop_idx), 38399);
    check("dflt_last_addr", last_addr, 1907);
    check("dflt_issues", 32'(d_issues), 38400);
    check("dflt_idle_valid", 32'(bus_d.st_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
